load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Sits between the core's load/store path and data memory; the only master on the data-memory port.
//  Splits B/H/W accesses into word address + byte-enables, lane-replicates store data, extracts and
//  sign/zero-extends load data, and stalls the core while a request is in flight.
//  Memory side is a req/ready handshake with byte enables; one access outstanding at a time.
// PARAMETERS
//  TIMEOUT_CYCLES  0   max BUSY cycles waiting for mem_ready_i; 0 = watchdog disabled
// PORTS
//  clk_i           in   1   clock, all state on posedge
//  rst_ni          in   1   asynchronous, active-low reset
//  core_req_i      in   1   core requests a load/store this cycle
//  core_we_i       in   1   1 = store, 0 = load
//  core_size_i     in   3   0=B 1=H 2=W 4=BU 5=HU; 3,6,7 treated as W
//  core_addr_i     in   32  byte address
//  core_wd_i       in   32  store data (low bits significant for B/H)
//  core_rd_o       out  32  extended load data, valid while state==RESP
//  core_stall_o    out  1   hold core pipeline
//  core_err_o      out  1   1-cycle pulse in RESP: misaligned (macro) or timeout
//  mem_req_o       out  1   request to data memory
//  mem_we_o        out  1   write enable
//  mem_be_o        out  4   byte enables (store); 4'b1111 on loads
//  mem_addr_o      out  32  {addr[31:2],2'b00}
//  mem_wd_o        out  32  lane-replicated store data
//  mem_rd_i        in   32  memory read word, valid when mem_ready_i=1
//  mem_ready_i     in   1   memory accepts/completes the current request this cycle
// BEHAVIOUR
//  Reset (rst_ni=0, async): state=IDLE; all capture regs, core_rd_o, core_err_o, mem_* outputs = 0.
//  FSM IDLE/BUSY/RESP:
//   IDLE: core_req_i=1 -> capture we/size/addr/wd, -> BUSY. mem_req_o=0.
//   BUSY: mem_req_o=1, mem_* driven only from captured regs (stable until ready).
//         mem_ready_i=1 -> register mem_rd_i, -> RESP. Watchdog: after TIMEOUT_CYCLES BUSY cycles
//         with no ready (TIMEOUT_CYCLES>0), drop req, err=1, rd=0, -> RESP.
//   RESP: 1 cycle, core_rd_o valid, core_stall_o=0, -> IDLE unconditionally.
//  core_stall_o = core_req_i && state!=RESP (combinational); min latency: req cycle0, BUSY cycle1,
//   RESP cycle2 -> 2 stalled cycles with zero-wait memory; +1 per cycle mem_ready_i is low.
//  core_req_i dropping while BUSY: access still completes, RESP still taken, data discarded.
//  Byte lane k = addr[1:0]. Stores: B be=4'b0001<<k, wd={4{wd[7:0]}}; H be=4'b0011<<{addr[1],0},
//   wd={2{wd[15:0]}}; W be=4'b1111, wd=wd. mem_be_o=0 while not BUSY.
//  Loads: B/BU take mem_rd[8k+:8], H/HU take mem_rd[16*addr[1]+:16]; B/H sign-, BU/HU zero-extend.
//  Store completion in RESP: core_rd_o=0.
//  core_rd_o held from RESP until next RESP (or reset).
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 skips BUSY entirely:
//   IDLE -> RESP directly, mem_req_o never asserted, core_err_o=1, core_rd_o=0.
//  Not defined: no check; low address bits ignored as per lane rules above (forced alignment);
//   core_err_o only from watchdog.
// TESTING
//  1 Store W 0xDEADBEEF @0x10, ready immediate -> mem_be=1111, mem_addr=0x10, stall 2 cycles.
//  2 Store B 0xA5 @0x13 -> mem_be=1000, mem_wd=0xA5A5A5A5; Load B @0x13 with mem_rd=0xA5000000
//    -> rd=0xFFFFFFA5; Load BU same -> 0x000000A5.
//  3 Load H @0x12, mem_rd=0x8001xxxx -> rd=0xFFFF8001; HU -> 0x00008001.
//  4 mem_ready_i low 3 cycles in BUSY -> mem_* stable, stall 5 cycles, data correct in RESP.
//  5 TIMEOUT_CYCLES=4, ready never -> err pulse in RESP after 4 BUSY cycles, rd=0, back to IDLE.
//  6 With LSU_MISALIGN_TRAP_EN: Load W @0x11 -> no mem_req_o, err=1, RESP in cycle1; rst_ni low
//    mid-BUSY -> mem_req_o=0 immediately, state IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: splits core B/H/W accesses into word requests with byte enables.
// It extracts and extends load data, and stalls the core while an access is in flight.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of forcing alignment.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam bit          WdogEn      = (TIMEOUT_CYCLES > 0);
    localparam logic [31:0] TimeoutLast = WdogEn ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic        isByte, isHalf, busy, misaligned;
    logic [1:0]  lane;
    logic [3:0]  storeBe;
    logic [31:0] storeWd, loadData;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Sizes 0/4 are bytes and 1/5 halves; every other encoding behaves as a word.
    assign isByte = (size_q[1:0] == 2'b00);
    assign isHalf = (size_q[1:0] == 2'b01);
    assign lane   = addr_q[1:0];
    assign busy   = (state_q == BUSY);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = ((core_size_i[1:0] == 2'b01) && core_addr_i[0]) ||
                        (core_size_i[1] && (core_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign byteSel = mem_rd_i[{lane, 3'b000} +: 8];
    assign halfSel = mem_rd_i[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        storeBe  = 4'b1111;
        storeWd  = wd_q;
        loadData = mem_rd_i;
        if (isByte) begin
            storeBe  = 4'b0001 << lane;
            storeWd  = {4{wd_q[7:0]}};
            loadData = {{24{~size_q[2] & byteSel[7]}}, byteSel};
        end else if (isHalf) begin
            storeBe  = addr_q[1] ? 4'b1100 : 4'b0011;
            storeWd  = {2{wd_q[15:0]}};
            loadData = {{16{~size_q[2] & halfSel[15]}}, halfSel};
        end
    end

    // Memory outputs are gated so they only reflect the captured access while BUSY.
    assign mem_req_o    = busy;
    assign mem_we_o     = busy & we_q;
    assign mem_be_o     = busy ? (we_q ? storeBe : 4'b1111) : 4'b0000;
    assign mem_addr_o   = busy ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wd_o     = busy ? storeWd : 32'd0;
    assign core_rd_o    = rd_q;
    assign core_err_o   = err_q;
    assign core_stall_o = core_req_i && (state_q != RESP);

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    we_d   = core_we_i;
                    size_d = core_size_i;
                    addr_d = core_addr_i;
                    wd_d   = core_wd_i;
                    cnt_d  = 32'd0;
                    if (misaligned) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rd_d    = 32'd0;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (mem_ready_i) begin
                    rd_d    = we_q ? 32'd0 : loadData;
                    state_d = RESP;
                end else if (WdogEn && (cnt_q == TimeoutLast)) begin
                    rd_d    = 32'd0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'd0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed accesses plus random ones
// checked against an arithmetic model of lane selection, extension and timing.
module tb_load_store_unit;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        coreReq, coreWe;
    logic [2:0]  coreSize;
    logic [31:0] coreAddr, coreWd, coreRd;
    logic        coreStall, coreErr;
    logic        memReq, memWe, memReady;
    logic [3:0]  memBe;
    logic [31:0] memAddr, memWd, memRd;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] lastRd = 32'd0;

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i(clk), .rst_ni(rstN),
        .core_req_i(coreReq), .core_we_i(coreWe), .core_size_i(coreSize),
        .core_addr_i(coreAddr), .core_wd_i(coreWd), .core_rd_o(coreRd),
        .core_stall_o(coreStall), .core_err_o(coreErr),
        .mem_req_o(memReq), .mem_we_o(memWe), .mem_be_o(memBe),
        .mem_addr_o(memAddr), .mem_wd_o(memWd),
        .mem_rd_i(memRd), .mem_ready_i(memReady)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: access width in bytes, and what memory/core should see.
    function automatic int accBytes(input logic [2:0] size);
        case (size)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit modelTrap(input logic [2:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
        return (addr % accBytes(size)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] modelBe(input logic we, input logic [2:0] size, input logic [31:0] addr);
        if (!we) return 4'hF;
        case (accBytes(size))
            1:       return 4'(1 << (addr % 4));
            2:       return 4'(3 << (2 * ((addr % 4) / 2)));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] modelWd(input logic [2:0] size, input logic [31:0] wd);
        case (accBytes(size))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] modelRd(input logic we, input logic [2:0] size,
                                            input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] v;
        if (we) return 32'd0;
        case (accBytes(size))
            1: begin
                v = (word >> (8 * (addr % 4))) & 32'hFF;
                if (size < 4 && v >= 128) v = v - 32'd256;
            end
            2: begin
                v = (word >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
                if (size < 4 && v >= 32768) v = v - 32'd65536;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    task automatic applyStimulus(input logic we, input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wd);
        coreReq  = 1'b1;
        coreWe   = we;
        coreSize = size;
        coreAddr = addr;
        coreWd   = wd;
    endtask

    // Runs one access starting just after a rising edge with the DUT idle.
    task automatic runAccess(input string tag, input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [31:0] word, input int waits);
        int          stalls;
        logic [31:0] expRd;
        stalls = 0;
        applyStimulus(we, size, addr, wd);
        memReady = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".idleReq"}, 32'(memReq), 32'd0);
        if (coreStall) stalls++;
        @(posedge clk); #1;
        if (modelTrap(size, addr)) begin
            @(negedge clk);
            checkOutput({tag, ".trapStall"}, 32'(coreStall), 32'd0);
            checkOutput({tag, ".trapErr"}, 32'(coreErr), 32'd1);
            checkOutput({tag, ".trapRd"}, coreRd, 32'd0);
            checkOutput({tag, ".trapReq"}, 32'(memReq), 32'd0);
            lastRd = 32'd0;
        end else begin
            for (int c = 0; c <= waits; c++) begin
                if (c == waits) begin
                    memReady = 1'b1;
                    memRd    = word;
                end else begin
                    memRd = $urandom;
                end
                @(negedge clk);
                if (coreStall) stalls++;
                checkOutput({tag, ".memReq"}, 32'(memReq), 32'd1);
                checkOutput({tag, ".memWe"}, 32'(memWe), 32'(we));
                checkOutput({tag, ".memBe"}, 32'(memBe), 32'(modelBe(we, size, addr)));
                checkOutput({tag, ".memAddr"}, memAddr, addr - (addr % 4));
                if (we) checkOutput({tag, ".memWd"}, memWd, modelWd(size, wd));
                @(posedge clk); #1;
            end
            memReady = 1'b0;
            memRd    = $urandom;
            expRd    = modelRd(we, size, addr, word);
            @(negedge clk);
            checkOutput({tag, ".stallCycles"}, 32'(stalls), 32'(2 + waits));
            checkOutput({tag, ".respStall"}, 32'(coreStall), 32'd0);
            checkOutput({tag, ".respErr"}, 32'(coreErr), 32'd0);
            checkOutput({tag, ".respRd"}, coreRd, expRd);
            checkOutput({tag, ".respReq"}, 32'(memReq), 32'd0);
            lastRd = expRd;
        end
        coreReq = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({tag, ".heldRd"}, coreRd, lastRd);
        checkOutput({tag, ".idleErr"}, 32'(coreErr), 32'd0);
        checkOutput({tag, ".idleBe"}, 32'(memBe), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   busyCycles;
        bit   done;
        logic [31:0] rAddr, rWd, rWord;
        logic [2:0]  rSize;
        logic        rWe;

        rstN = 1'b0; coreReq = 1'b0; coreWe = 1'b0; coreSize = 3'd0;
        coreAddr = 32'd0; coreWd = 32'd0; memRd = 32'd0; memReady = 1'b0;
        #1;
        checkOutput("rst.memReq", 32'(memReq), 32'd0);
        checkOutput("rst.memWe", 32'(memWe), 32'd0);
        checkOutput("rst.memBe", 32'(memBe), 32'd0);
        checkOutput("rst.memAddr", memAddr, 32'd0);
        checkOutput("rst.memWd", memWd, 32'd0);
        checkOutput("rst.coreRd", coreRd, 32'd0);
        checkOutput("rst.coreErr", 32'(coreErr), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;

        runAccess("storeW", 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
        runAccess("storeB", 1'b1, 3'd0, 32'h13, 32'h0000_00A5, 32'h0, 0);
        runAccess("loadB", 1'b0, 3'd0, 32'h13, 32'h0, 32'hA500_0000, 0);
        runAccess("loadBU", 1'b0, 3'd4, 32'h13, 32'h0, 32'hA500_0000, 0);
        runAccess("loadH", 1'b0, 3'd1, 32'h12, 32'h0, 32'h8001_1234, 0);
        runAccess("loadHU", 1'b0, 3'd5, 32'h12, 32'h0, 32'h8001_1234, 0);
        runAccess("storeH", 1'b1, 3'd1, 32'h22, 32'h1234_BEEF, 32'h0, 1);
        runAccess("wait3", 1'b0, 3'd2, 32'h30, 32'h0, 32'hCAFE_F00D, 3);
        runAccess("loadWmis", 1'b0, 3'd2, 32'h11, 32'h0, 32'h1357_9BDF, 0);
        runAccess("loadHodd", 1'b0, 3'd1, 32'h15, 32'h0, 32'h7FFF_8000, 0);

        // Watchdog: memory never answers.
        applyStimulus(1'b0, 3'd2, 32'h20, 32'h0);
        memReady = 1'b0;
        @(posedge clk); #1;
        busyCycles = 0;
        done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            @(negedge clk);
            if (memReq) begin
                busyCycles++;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        checkOutput("wdog.reachedResp", 32'(done), 32'd1);
        checkOutput("wdog.busyCycles", 32'(busyCycles), 32'(TIMEOUT));
        checkOutput("wdog.err", 32'(coreErr), 32'd1);
        checkOutput("wdog.rd", coreRd, 32'd0);
        checkOutput("wdog.stall", 32'(coreStall), 32'd0);
        lastRd = 32'd0;
        coreReq = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("wdog.errPulse", 32'(coreErr), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            rWe   = 1'($urandom_range(0, 1));
            rSize = 3'($urandom_range(0, 7));
            rAddr = $urandom;
            rWd   = $urandom;
            rWord = $urandom;
            runAccess($sformatf("rnd%0d", i), rWe, rSize, rAddr, rWd, rWord, int'($urandom_range(0, 3)));
        end

        // Asynchronous reset while an access is waiting on memory.
        applyStimulus(1'b0, 3'd2, 32'h40, 32'h0);
        memReady = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rstBusy.reqBefore", 32'(memReq), 32'd1);
        #1 rstN = 1'b0;
        #1;
        checkOutput("rstBusy.memReq", 32'(memReq), 32'd0);
        checkOutput("rstBusy.memBe", 32'(memBe), 32'd0);
        checkOutput("rstBusy.coreRd", coreRd, 32'd0);
        checkOutput("rstBusy.stall", 32'(coreStall), 32'd1);
        coreReq = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rstBusy.idleReq", 32'(memReq), 32'd0);
        checkOutput("rstBusy.idleStall", 32'(coreStall), 32'd0);
        @(posedge clk); #1;
        lastRd = 32'd0;
        runAccess("afterRst", 1'b0, 3'd0, 32'h41, 32'h0, 32'h0000_8000, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
